img_fetch: RTL
==============

# img_fetch

Responder end of the sweeper's address stream. Accepts (x, y) pixel coordinates over a valid/ready handshake, converts them to a linear image-RAM address, and issues a read to a 1-cycle-latency synchronous RAM. Returns pixel data in request order over a second valid/ready stream toward the feature evaluator. A small credit-tracked FIFO absorbs downstream back-pressure without dropping in-flight reads.

## Interface
Parameters:
- IMG_WIDTH, 320, image width in pixels; W_X = $clog2(IMG_WIDTH)
- IMG_HEIGHT, 240, image height in pixels; W_Y = $clog2(IMG_HEIGHT)
- W_PIX, 8, pixel data width
- FIFO_DEPTH, 4, return buffer entries (power of two, >= 2)
- W_ADDR, derived = $clog2(IMG_WIDTH*IMG_HEIGHT), RAM address width

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- addr_valid  in  1  request valid from sweeper
- addr_ready  out  1  request accepted when addr_valid & addr_ready
- x  in  W_X  request column
- y  in  W_Y  request row
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  W_ADDR  RAM read address
- mem_rdata  in  W_PIX  RAM data, valid the cycle after mem_rd_en
- pix_valid  out  1  returned pixel valid
- pix_ready  in  1  consumer ready
- pix_data  out  W_PIX  returned pixel

## Operation
- Request handshake: acc = addr_valid & addr_ready. addr_valid must not depend on addr_ready.
- Address: mem_addr = y * IMG_WIDTH + x, computed combinationally at full W_ADDR width (operands zero-extended before multiply; no truncation of the product).
- mem_rd_en = acc & in_range, where in_range = (x < IMG_WIDTH) & (y < IMG_HEIGHT).
- Out-of-range request: accepted normally, no RAM read issued, returns pix_data = 0 in its ordered slot.
- Pipeline: 1-bit in-flight register inf (set by acc, else cleared) plus oob flag register. Cycle after acc: FIFO push of (oob ? 0 : mem_rdata).
- Credits: occ = fifo_count + inf. addr_ready = (occ < FIFO_DEPTH) & rst_n. Guarantees every issued read has a FIFO slot; FIFO never overflows.
- FIFO: circular, wr/rd pointers of $clog2(FIFO_DEPTH) bits wrapping modulo depth, count of $clog2(FIFO_DEPTH)+1 bits.
- Output: pix_valid = (count != 0); pix_data = FIFO head. Pop on pix_valid & pix_ready.
- Ordering: responses strictly in request order, one per accepted request, none dropped or duplicated.

## Timing
- Reset (rst_n low, asynchronous): pointers, count, inf, oob cleared. pix_valid = 0, addr_ready = 0, mem_rd_en = 0 while reset asserted; addr_ready = 1 the first cycle after release (with addr_valid present, acceptance is immediate).
- Latency: request accepted cycle N -> pix_valid at cycle N+2 (earliest), pix_data = RAM word at mem_addr.
- Throughput: 1 request/cycle sustained while pix_ready held high.
- Simultaneous push and pop: count unchanged; legal when FIFO full (count == FIFO_DEPTH) and when empty-with-push is not a pop (no pop when count == 0; no bypass).
- Back-pressure: with pix_ready low, exactly FIFO_DEPTH requests accepted in total, then addr_ready low until a pop; addr_ready rises the cycle after the first pop.
- Reset mid-operation: in-flight read and buffered pixels discarded; no pix_valid after reset until a new request.
- Pointer wrap: rd/wr pointers wrap from FIFO_DEPTH-1 to 0 without losing an entry.

## Test plan
- Single read: RAM[a] = a[7:0]; request (x=5, y=2) -> mem_rd_en high with mem_addr = 645 same cycle, pix_valid at +2 cycles with pix_data = 0x85.
- Full sweep: stream all 320x240 coordinates in raster order, pix_ready = 1 -> 76800 pixels, in order, one per cycle after 2-cycle fill, each equal to RAM[y*320+x]; last address 76799.
- Back-pressure: pix_ready = 0, addr_valid = 1 constant -> exactly 4 acceptances, addr_ready low thereafter; raise pix_ready one cycle -> one pop, addr_ready high next cycle; data order preserved.
- Out-of-range: request (x=320, y=0) between two valid requests -> no mem_rd_en for it, returned sequence = valid, 0x00, valid.
- Random stall: random addr_valid and pix_ready (50%) over 10000 requests -> scoreboard matches in order, occ never exceeds 4, no pop on empty.
- Mid-run reset: assert rst_n low with 3 pixels buffered and 1 in flight -> pix_valid and addr_ready low immediately; after release, no stale pixel emitted, next request (x=0, y=0) returns RAM[0].

Source files
------------

// File: rtl/img_fetch_if.sv
// img_fetch_if
//   Bundles the three streams around img_fetch:
//     request stream  : addr_valid, addr_ready, x, y       (sweeper -> fetch)
//     RAM read port   : mem_rd_en, mem_addr, mem_rdata     (fetch <-> image RAM)
//     pixel stream    : pix_valid, pix_ready, pix_data     (fetch -> evaluator)
//   modport slave  : the fetch block's view
//   modport master : the surrounding system's view (sweeper, RAM, evaluator)
interface img_fetch_if #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int W_PIX      = 8
);
  localparam int W_X    = $clog2(IMG_WIDTH);
  localparam int W_Y    = $clog2(IMG_HEIGHT);
  localparam int W_ADDR = $clog2(IMG_WIDTH * IMG_HEIGHT);

  logic              addr_valid;
  logic              addr_ready;
  logic [W_X-1:0]    x;
  logic [W_Y-1:0]    y;
  logic              mem_rd_en;
  logic [W_ADDR-1:0] mem_addr;
  logic [W_PIX-1:0]  mem_rdata;
  logic              pix_valid;
  logic              pix_ready;
  logic [W_PIX-1:0]  pix_data;

  modport slave (
    input  addr_valid, x, y, mem_rdata, pix_ready,
    output addr_ready, mem_rd_en, mem_addr, pix_valid, pix_data
  );

  modport master (
    output addr_valid, x, y, mem_rdata, pix_ready,
    input  addr_ready, mem_rd_en, mem_addr, pix_valid, pix_data
  );
endinterface

// File: rtl/img_fetch.sv
// img_fetch
//   Takes (x, y) pixel requests, reads the image RAM (1-cycle latency) at
//   y*IMG_WIDTH + x and returns pixels in request order through a small
//   return FIFO. Admission is credit based: a request is only accepted when
//   the FIFO can hold it together with any read still in flight, so
//   back-pressure on the pixel stream never drops a read.
//   Out-of-range coordinates are accepted, skip the RAM and return 0.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : img_fetch_if.slave (request stream, RAM read port, pixel stream)
module img_fetch #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int W_PIX      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  img_fetch_if.slave  bus
);
  localparam int W_X    = $clog2(IMG_WIDTH);
  localparam int W_Y    = $clog2(IMG_HEIGHT);
  localparam int W_ADDR = $clog2(IMG_WIDTH * IMG_HEIGHT);
  localparam int W_PTR  = $clog2(FIFO_DEPTH);
  localparam int W_CNT  = W_PTR + 1;

  logic [W_PTR-1:0] wr_ptr, rd_ptr;
  logic [W_CNT-1:0] count;
  logic [W_CNT-1:0] occ;
  logic             inf;
  logic             oob;
  logic             in_range;
  logic             acc;
  logic             push;
  logic             pop;
  logic [W_PIX-1:0] buf_q [FIFO_DEPTH];

  // Compare one bit wider so a power-of-two image size still works.
  assign in_range = ({1'b0, bus.x} < (W_X+1)'(IMG_WIDTH)) &&
                    ({1'b0, bus.y} < (W_Y+1)'(IMG_HEIGHT));

  // Occupancy counts the read in flight so it always has a slot waiting.
  assign occ            = count + W_CNT'(inf);
  assign bus.addr_ready = (occ < W_CNT'(FIFO_DEPTH)) && rst_n;
  assign acc            = bus.addr_valid && bus.addr_ready;

  assign bus.mem_rd_en = acc && in_range;
  assign bus.mem_addr  = W_ADDR'(bus.y) * W_ADDR'(IMG_WIDTH) + W_ADDR'(bus.x);

  assign push          = inf;
  assign pop           = (count != '0) && bus.pix_ready;
  assign bus.pix_valid = (count != '0);
  assign bus.pix_data  = buf_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      inf    <= 1'b0;
      oob    <= 1'b0;
    end else begin
      inf <= acc;
      oob <= acc && !in_range;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr] <= oob ? '0 : bus.mem_rdata;
  end
endmodule
